// File: rtl/regfile_sb.sv
// Parametrised register file with two combinational read ports, one write port,
// same-cycle write bypass and a per-register pending scoreboard for hazard detection.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              reg_clk,
  input  logic              reg_rst_n,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] write_3,
  input  logic [DATA_W-1:0] write_data_p3,
  input  logic [ADDR_W-1:0] read_1,
  input  logic [ADDR_W-1:0] read_2,
  output logic [DATA_W-1:0] read_data_p1,
  output logic [DATA_W-1:0] read_data_p2,
  output logic              busy_p1,
  output logic              busy_p2,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              any_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              anyBusy_q;
  logic              wrValid, claimValid;

  logic [ADDR_W-1:0] rdAddr [2];
  logic [DATA_W-1:0] rdData [2];
  logic [1:0]        rdBusy;

  assign wrValid    = regwrite && (write_3 != '0);
  assign claimValid = claim_en && (claim_addr != '0);

  // Release first, then claim: a new producer issued on the retiring edge keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (wrValid) begin
      pend_d[write_3] = 1'b0;
    end
    if (claimValid) begin
      pend_d[claim_addr] = 1'b1;
    end
  end

  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wrValid) begin
      regs_q[write_3] <= write_data_p3;
    end
  end

  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      pend_q    <= '0;
      anyBusy_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      anyBusy_q <= |pend_d;
    end
  end

  assign rdAddr[0] = read_1;
  assign rdAddr[1] = read_2;

  // Outputs are forced quiet while reset is held so the bypass cannot leak write data.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdData[p] = '0;
      rdBusy[p] = 1'b0;
      if (reg_rst_n && (rdAddr[p] != '0)) begin
        if ((BYPASS != 0) && regwrite && (write_3 == rdAddr[p])) begin
          rdData[p] = write_data_p3;
        end else begin
          rdData[p] = regs_q[rdAddr[p]];
          rdBusy[p] = pend_q[rdAddr[p]];
        end
      end
    end
  end

  assign read_data_p1 = rdData[0];
  assign read_data_p2 = rdData[1];
  assign busy_p1      = rdBusy[0];
  assign busy_p2      = rdBusy[1];
  assign any_busy     = anyBusy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance
// share stimulus; table vectors plus hand-written reset sequences.
module tb_regfile_sb;

  logic        clock;
  logic        rstN;
  logic        regwrite;
  logic [4:0]  wAddr;
  logic [31:0] wData;
  logic [4:0]  rd1, rd2;
  logic        claimEn;
  logic [4:0]  claimAddr;

  logic [31:0] d1, d2, d1nb, d2nb;
  logic        b1, b2, b1nb, b2nb, anyB, anyBnb;

  int total = 0;
  int bad   = 0;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .reg_clk(clock), .reg_rst_n(rstN), .regwrite(regwrite), .write_3(wAddr),
    .write_data_p3(wData), .read_1(rd1), .read_2(rd2),
    .read_data_p1(d1), .read_data_p2(d2), .busy_p1(b1), .busy_p2(b2),
    .claim_en(claimEn), .claim_addr(claimAddr), .any_busy(anyB)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dutNb (
    .reg_clk(clock), .reg_rst_n(rstN), .regwrite(regwrite), .write_3(wAddr),
    .write_data_p3(wData), .read_1(rd1), .read_2(rd2),
    .read_data_p1(d1nb), .read_data_p2(d2nb), .busy_p1(b1nb), .busy_p2(b2nb),
    .claim_en(claimEn), .claim_addr(claimAddr), .any_busy(anyBnb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ce;
    logic [4:0]  ca;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] expD1;
    logic [31:0] expD2;
    logic        expB1;
    logic        expB2;
    logic        expAny;
    logic [31:0] expD1nb;
    logic        expB1nb;
  } vec_t;

  vec_t vecs [17];

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic ce, input logic [4:0] ca,
                               input logic [4:0] r1, input logic [4:0] r2);
    regwrite  = we;
    wAddr     = wa;
    wData     = wd;
    claimEn   = ce;
    claimAddr = ca;
    rd1       = r1;
    rd2       = r2;
  endtask

  initial begin
    // State after each vector's edge feeds the expectations of the next vector.
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd31, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd7, 5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 5'd7, 5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd9, 5'd7,  32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd9, 5'd3,  32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3,  32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 5'd3, 32'h55,       1'b0, 5'd0, 5'd3, 5'd9,  32'h55,       32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3,  32'h55,       32'h55,       1'b0, 1'b0, 1'b0, 32'h55,       1'b0};
    vecs[8]  = '{1'b1, 5'd4, 32'h77,       1'b1, 5'd4, 5'd4, 5'd0,  32'h77,       32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd4,  32'h77,       32'h77,       1'b1, 1'b1, 1'b1, 32'h77,       1'b1};
    vecs[10] = '{1'b1, 5'd4, 32'h88,       1'b0, 5'd0, 5'd4, 5'd4,  32'h88,       32'h88,       1'b0, 1'b0, 1'b1, 32'h77,       1'b1};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd4,  32'h88,       32'h88,       1'b0, 1'b0, 1'b0, 32'h88,       1'b0};
    vecs[12] = '{1'b1, 5'd0, 32'hFFFF,     1'b1, 5'd0, 5'd0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[13] = '{1'b1, 5'd6, 32'h66,       1'b1, 5'd5, 5'd6, 5'd5,  32'h66,       32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd6,  32'h0,        32'h66,       1'b1, 1'b0, 1'b1, 32'h0,        1'b1};
    vecs[15] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 5'd5, 5'd5,  32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 32'h0,        1'b1};
    vecs[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        1'b1};

    // Hold reset with an active write to r7; the bypass must not leak through.
    rstN = 1'b0;
    applyStimulus(1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 5'd7, 5'd7, 5'd31);
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    checkOutput("rst_d1", -1, d1, 32'h0);
    checkOutput("rst_b1", -1, {31'b0, b1}, 32'h0);
    checkOutput("rst_any", -1, {31'b0, anyB}, 32'h0);
    rstN = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);

    // Table vectors: drive at negedge, sample just after, commit on the next posedge.
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ce, vecs[i].ca,
                    vecs[i].r1, vecs[i].r2);
      #1;
      checkOutput("d1", i, d1, vecs[i].expD1);
      checkOutput("d2", i, d2, vecs[i].expD2);
      checkOutput("b1", i, {31'b0, b1}, {31'b0, vecs[i].expB1});
      checkOutput("b2", i, {31'b0, b2}, {31'b0, vecs[i].expB2});
      checkOutput("any", i, {31'b0, anyB}, {31'b0, vecs[i].expAny});
      checkOutput("d1_nobyp", i, d1nb, vecs[i].expD1nb);
      checkOutput("b1_nobyp", i, {31'b0, b1nb}, {31'b0, vecs[i].expB1nb});
      checkOutput("any_nobyp", i, {31'b0, anyBnb}, {31'b0, vecs[i].expAny});
    end

    // Async reset mid-operation: r6 = 0x99 and pending, then pulse reset between edges.
    @(negedge clock);
    applyStimulus(1'b1, 5'd6, 32'h99, 1'b1, 5'd6, 5'd0, 5'd0);
    @(negedge clock);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd6);
    #1;
    checkOutput("pre_rst_d1", 100, d1, 32'h99);
    checkOutput("pre_rst_b2", 100, {31'b0, b2}, 32'h1);
    checkOutput("pre_rst_any", 100, {31'b0, anyB}, 32'h1);
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_d1", 101, d1, 32'h0);
    checkOutput("mid_rst_b1", 101, {31'b0, b1}, 32'h0);
    checkOutput("mid_rst_d2_nobyp", 101, d2nb, 32'h0);
    checkOutput("mid_rst_any", 101, {31'b0, anyB}, 32'h0);
    rstN = 1'b1;
    #1;
    checkOutput("post_rst_d2", 102, d2, 32'h0);
    checkOutput("post_rst_b2", 102, {31'b0, b2}, 32'h0);
    rd1 = 5'd5;
    #1;
    checkOutput("post_rst_b1_r5", 102, {31'b0, b1}, 32'h0);
    @(posedge clock);
    #1;
    checkOutput("post_rst_any_edge", 103, {31'b0, anyB}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the 32x32 MIPS register file. It has two combinational read ports and one synchronous write port. It adds an asynchronous clear, a write-to-read bypass, and a per-register pending scoreboard for pipeline hazard detection. It sits between decode/issue, which reads operands and claims destinations, and writeback, which writes results and releases claims.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
BYPASS, 1, 1 = same-cycle write data and release are forwarded to the read ports; 0 = reads return stored state only

Ports:
reg_clk  input  1  clock; all state updates on the rising edge
reg_rst_n  input  1  asynchronous active-low reset
regwrite  input  1  write enable for port 3
write_3  input  ADDR_W  write address
write_data_p3  input  DATA_W  write data
read_1  input  ADDR_W  read address, port 1
read_2  input  ADDR_W  read address, port 2
read_data_p1  output  DATA_W  read data, port 1
read_data_p2  output  DATA_W  read data, port 2
busy_p1  output  1  register read_1 has an outstanding claim
busy_p2  output  1  register read_2 has an outstanding claim
claim_en  input  1  mark register claim_addr as pending
claim_addr  input  ADDR_W  destination being claimed
any_busy  output  1  OR of all pending bits, registered view

Behaviour:
- Reset: when reg_rst_n = 0, immediately (asynchronously) clear all registers to 0 and all pending bits to 0. While reset is held, outputs are read_data = 0, busy = 0, any_busy = 0. Writes and claims are ignored during reset. Release is synchronous to reg_clk, with no special handling beyond the flop reset.
- Register 0:
  - Hardwired. Writes to it are discarded, claims to it are discarded.
  - Reads of address 0 return 0 with busy = 0, regardless of bypass.
- Write: on a rising edge with regwrite = 1 and write_3 != 0, store write_data_p3 in regs[write_3] and clear pend[write_3].
- Claim: on a rising edge with claim_en = 1 and claim_addr != 0, set pend[claim_addr].
- Claim and write to the same address on the same edge:
  - Data is written.
  - Pending ends at 1; the claim wins, because a new producer was issued while the old one retires.
- Claim and write to different addresses on the same edge: both take effect independently.
- Claim of an already-pending register: stays 1. There is no count; only the latest producer matters.
- Write to a non-pending register: legal; data is stored and pending stays 0.
- Reads are combinational, zero latency. For port n (n = 1, 2):
  - If read_n == 0: data = 0, busy = 0.
  - Else if BYPASS = 1, regwrite = 1 and write_3 == read_n: data = write_data_p3, busy = 0 (the same-cycle release is forwarded).
  - Else: data = regs[read_n], busy = pend[read_n].
- The bypass does not consider claim_en in the same cycle. A claim only becomes visible on busy from the next cycle.
- BYPASS = 0: written data and released busy become visible the cycle after the edge.
- any_busy: a flop updated each edge from the next-state pending vector, so it reflects the state after that edge. Reset value is 0.
- Both read ports are fully independent; identical addresses on both ports give identical results.
- No X propagation out of reset: every register and pending bit has a defined reset value.

Test Plan:
- Reset then read: assert reg_rst_n = 0 mid-simulation, then release; read_1 = 5, read_2 = 31 -> both data 0, busy_p1/p2 = 0, any_busy = 0.
- Basic write/read: write 0xDEADBEEF to r7 on an edge, then read_1 = 7 next cycle -> 0xDEADBEEF. Writing 0x1234 to r0, then read_2 = 0 -> 0.
- Bypass: regwrite = 1, write_3 = 9, write_data_p3 = 0xA5A5A5A5, read_1 = 9 in the same cycle:
  - BYPASS = 1 -> read_data_p1 = 0xA5A5A5A5 combinationally.
  - BYPASS = 0 -> old value (0) this cycle, 0xA5A5A5A5 next cycle.
- Scoreboard:
  - Claim r3 -> next cycle busy_p1 = 1 for read_1 = 3 and any_busy = 1.
  - Write r3 = 0x55 -> with BYPASS = 1, busy_p1 = 0 and data 0x55 in the same cycle; after the edge, any_busy = 0.
- Simultaneous claim and write to r4 (write 0x77): after the edge, regs[4] = 0x77, busy = 1, any_busy = 1. A later write of r4 = 0x88 clears busy.
- Async reset mid-operation: r6 = 0x99 and r6 pending; pulse reg_rst_n low between clock edges -> data 0 and busy 0 immediately, without waiting for a clock edge.
